// File: rtl/ads868x_scan_ctrl.sv
// ADS868x scan sequencer: steps the analog mux, triggers conversions, reads
// 32-bit SPI frames and emits channel-tagged 16-bit samples on a stream output.
module ads868x_scan_ctrl #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned CONV_CYCLES   = 70
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [2:0]  i_ch_last,
  output logic [2:0]  o_ch_sel,
  output logic        o_spi_sclk,
  output logic        o_spi_cs_n,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso,
  output logic [15:0] o_m_axis_tdata,
  output logic [2:0]  o_m_axis_tuser,
  output logic        o_m_axis_tvalid,
  input  logic        i_m_axis_tready,
  output logic        o_overflow,
  output logic        o_busy
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CH_W  = 3;
  localparam int unsigned BIT_W = 5;
  localparam int unsigned SR_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_TRIG, S_CONV, S_SHIFT, S_DONE
  } state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_ch_last;
  logic [CNT_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic [SR_W-1:0]   r_shift;

  logic [CH_W-1:0]   w_ch_adv;
  logic [CH_W-1:0]   w_ch_next;
  logic [CH_W-1:0]   w_ch_entry;

  // Channel for the next SETTLE: advance out of DONE, then clamp to the live ch_last
  assign w_ch_adv   = (r_ch == r_ch_last) ? '0 : r_ch + CH_W'(1);
  assign w_ch_next  = (r_state == S_DONE) ? w_ch_adv : r_ch;
  assign w_ch_entry = (w_ch_next > i_ch_last) ? '0 : w_ch_next;

  // NOP command frame
  assign o_spi_mosi = 1'b0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_ch            <= '0;
      r_ch_last       <= '0;
      r_cnt           <= '0;
      r_div           <= '0;
      r_bit           <= '0;
      r_shift         <= '0;
      o_ch_sel        <= '0;
      o_spi_sclk      <= 1'b0;
      o_spi_cs_n      <= 1'b1;
      o_m_axis_tdata  <= '0;
      o_m_axis_tuser  <= '0;
      o_m_axis_tvalid <= 1'b0;
      o_overflow      <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      if (o_m_axis_tvalid && i_m_axis_tready) begin
        o_m_axis_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state   <= S_SETTLE;
            r_ch      <= w_ch_entry;
            o_ch_sel  <= w_ch_entry;
            r_ch_last <= i_ch_last;
            r_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
            o_busy    <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state    <= S_TRIG;
            o_spi_cs_n <= 1'b0;
            r_cnt      <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_TRIG: begin
          if (r_cnt == '0) begin
            r_state    <= S_CONV;
            o_spi_cs_n <= 1'b1;
            r_cnt      <= CNT_W'(CONV_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_CONV: begin
          if (r_cnt == '0) begin
            r_state    <= S_SHIFT;
            o_spi_cs_n <= 1'b0;
            r_div      <= DIV_W'(CLK_DIV - 1);
            r_bit      <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        // Each bit: CLK_DIV cycles low, CLK_DIV high; capture on the rising edge
        S_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - DIV_W'(1);
          end else begin
            r_div      <= DIV_W'(CLK_DIV - 1);
            o_spi_sclk <= ~o_spi_sclk;
            if (!o_spi_sclk) begin
              r_shift <= {r_shift[SR_W-2:0], i_spi_miso};
            end else if (r_bit == BIT_W'(SR_W - 1)) begin
              r_state    <= S_DONE;
              o_spi_cs_n <= 1'b1;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end
        end

        S_DONE: begin
          if (!o_m_axis_tvalid || i_m_axis_tready) begin
            o_m_axis_tdata  <= r_shift[SR_W-1:SR_W-16];
            o_m_axis_tuser  <= r_ch;
            o_m_axis_tvalid <= 1'b1;
          end else begin
            o_overflow <= 1'b1;
          end
          r_ch <= w_ch_adv;
          if (i_enable) begin
            r_state   <= S_SETTLE;
            r_ch      <= w_ch_entry;
            o_ch_sel  <= w_ch_entry;
            r_ch_last <= i_ch_last;
            r_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ads868x_scan_ctrl.md
# ads868x_scan_ctrl

Acquisition sequencer for the ADS868x SAR ADC on the FPGA_SPI1 bus of the Coreboard1588. It steps the analog mux (CH_SEL_A) through channels 0..ch_last, waits for settling, triggers a conversion, reads the 16-bit result over SPI, and emits one channel-tagged sample on an AXI-Stream-style output. It sits between the FPGA_SPI1_*/CH_SEL_A board pins and the downstream sample buffer/DMA logic inside the block design.

## Interface
Parameters:
- CLK_DIV, 2: SCLK half-period in clk cycles. Legal range 1..255.
- SETTLE_CYCLES, 100: mux settling wait after a ch_sel change. Legal range 1..65535.
- CONV_CYCLES, 70: cs_n-high time for conversion. Legal range 1..65535.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = scan continuously, 0 = stop after the current channel completes.
- ch_last  in  3  last channel of the scan. Sampled on entry to SETTLE.
- ch_sel  out  3  analog mux select (CH_SEL_A[2:0]).
- spi_sclk  out  1  SPI clock, mode 0, idle low.
- spi_cs_n  out  1  ADC CONVST/CS; a rising edge starts a conversion.
- spi_mosi  out  1  constant 0 (NOP command frame).
- spi_miso  in  1  ADC data out. Treated as synchronous to clk; no synchronizer.
- m_axis_tdata  out  16  conversion result.
- m_axis_tuser  out  3  channel of tdata.
- m_axis_tvalid  out  1  output holding register valid.
- m_axis_tready  in  1  downstream accept.
- overflow  out  1  sticky; set when a sample is dropped. Cleared only by rst.
- busy  out  1  1 in every state except IDLE.

## Operation
- Reset values: ch_sel=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tvalid=0, overflow=0, busy=0. State=IDLE, channel counter=0.
- IDLE: cs_n=1.
  - enable=1 → SETTLE.
- SETTLE: ch_sel=current channel. Count SETTLE_CYCLES clk cycles → TRIG.
- TRIG: cs_n=0 for exactly 2 clk cycles with no SCLK → CONV. The cs_n rising edge at the start of CONV samples the current channel.
- CONV: cs_n=1 for CONV_CYCLES → SHIFT.
- SHIFT: cs_n=0 and 32 SCLK periods.
  - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MISO is shifted in MSB-first on the clk cycle in which SCLK goes high.
  - SCLK ends low. After the 32nd bit → DONE.
- DONE (1 cycle): cs_n=1. Sample = shift bits [31:16] (first 16 bits received).
  - If m_axis_tvalid=0, or m_axis_tready=1 in this cycle: load tdata/tuser and set tvalid=1.
  - Otherwise: drop the sample and set overflow=1. The held sample is kept unchanged.
  - Channel advance: if channel == ch_last, wrap to 0; else increment.
  - Next state: enable=1 → SETTLE; enable=0 → IDLE.
- Output handshake: a transfer occurs when tvalid & tready.
  - tvalid clears the cycle after a transfer, unless DONE reloads in that same cycle.
  - tdata/tuser stay stable while tvalid=1 and tready=0.
- ch_last is latched on SETTLE entry. If the latched channel counter is > ch_last, the counter resets to 0 before ch_sel is driven.
- Deasserting enable mid-channel has no effect until DONE; the frame always completes.
- rst asserted mid-frame: all outputs return to reset values immediately (asynchronous), and any partial frame is discarded.

## Timing
- Per-channel period = SETTLE_CYCLES + 2 + CONV_CYCLES + 64·CLK_DIV + 1 clk cycles. Defaults: 100+2+70+128+1 = 301 cycles.
- Latency from the cs_n rising edge (conversion start) to tvalid=1 (with the holding register free) = CONV_CYCLES + 64·CLK_DIV + 1 cycles.
- The state change IDLE→SETTLE happens on the first clk edge with enable=1. ch_sel updates on that same edge.
- spi_* and ch_sel are registered outputs; no combinational path from any input.
- The overflow sticky bit sets on the DONE edge that drops the sample.

## Test plan
- Reset: assert rst mid-SHIFT → cs_n=1, sclk=0, tvalid=0, busy=0 asynchronously; after release the block idles with enable=0.
- Single scan: ch_last=2, enable=1, tready=1, ADC model returns 0x1000+ch → outputs (0x1000,0), (0x1001,1), (0x1002,2), (0x1000,0) in order.
  - Check 301-cycle spacing.
  - Check ch_sel is stable from 100 cycles before each cs_n rising edge.
- SPI framing: ADC model drives 0xA5C3_xxxx → tdata=0xA5C3. Count exactly 32 SCLK pulses per frame, each with 2-cycle high and 2-cycle low. mosi=0 throughout.
- Backpressure: tready=0 for 2 channel periods → the first sample is held stable, the second is dropped, and overflow=1. With tready=1 the held sample transfers, and the next DONE loads normally.
- Stop/restart: deassert enable during CONV of ch1 → ch1 sample emitted, then IDLE with busy=0 and counter=2. Re-enable → the next ch_sel is 2.
- ch_last shrink: change ch_last from 7 to 1 while on ch5 → after ch5 completes, the counter wraps to 0 and the sequence continues 0,1,0.
